// File: rtl/fetch_predict_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_predict_if
// Description : Control, training, instruction-memory and IF/ID bundle of
//               the fetch/predict stage. The master side drives the
//               pipeline controls and the memory data. The slave side is the
//               fetch stage itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_predict_if;
  // pipeline control
  logic        stall;
  logic        flush;
  logic        redirect;
  logic [31:0] redirect_pc;
  // branch training from EX
  logic        update_en;
  logic [31:0] update_pc;
  logic        update_taken;
  logic [31:0] update_target;
  // instruction memory
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  // IF/ID register
  logic [31:0] instr_IF;
  logic [31:0] pc_IF;
  logic [31:0] pcnext_IF;
  logic        prediction_IF;

  modport master (
    output stall, flush, redirect, redirect_pc,
    output update_en, update_pc, update_taken, update_target,
    output imem_rdata,
    input  imem_addr,
    input  instr_IF, pc_IF, pcnext_IF, prediction_IF
  );

  modport slave (
    input  stall, flush, redirect, redirect_pc,
    input  update_en, update_pc, update_taken, update_target,
    input  imem_rdata,
    output imem_addr,
    output instr_IF, pc_IF, pcnext_IF, prediction_IF
  );
endinterface
`default_nettype wire

// File: rtl/fetch_predict_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_predict_stage
// Description : Instruction fetch stage with PC register, IF/ID pipeline
//               register and an optional direct-mapped branch target buffer
//               with 2-bit saturating counters. The predictor is built only
//               when the macro BRANCH_PREDICT_EN is defined. Otherwise the
//               next PC is the redirect target, the held PC or PC+4.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_predict_stage #(
  parameter int BHT_IDX_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  fetch_predict_if.slave  bus
);

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_plus4;
  logic        predict_taken;
  logic [31:0] predict_target;

  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_if_q, pc_if_d;
  logic [31:0] pcnext_q, pcnext_d;
  logic        pred_q, pred_d;

  assign pc_plus4      = pc_q + 32'd4;
  assign bus.imem_addr = pc_q;

`ifdef BRANCH_PREDICT_EN
  localparam int ENTRIES = 1 << BHT_IDX_W;
  localparam int TAG_W   = 30 - BHT_IDX_W;

  logic [1:0]         cnt_q [ENTRIES];
  logic [1:0]         cnt_d [ENTRIES];
  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [TAG_W-1:0]   tag_d [ENTRIES];
  logic [31:0]        tgt_q [ENTRIES];
  logic [31:0]        tgt_d [ENTRIES];

  logic [BHT_IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0]     lk_tag, up_tag;
  logic                 unused_upd_lsbs;

  assign lk_idx          = pc_q[1+BHT_IDX_W:2];
  assign lk_tag          = pc_q[31:2+BHT_IDX_W];
  assign up_idx          = bus.update_pc[1+BHT_IDX_W:2];
  assign up_tag          = bus.update_pc[31:2+BHT_IDX_W];
  assign unused_upd_lsbs = ^bus.update_pc[1:0];

  // Lookup of the current PC; reads pre-update table contents.
  always_comb begin
    predict_taken  = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag) && cnt_q[lk_idx][1];
    predict_target = tgt_q[lk_idx];
  end

  // Training from resolved branches, independent of stall/flush/redirect.
  always_comb begin
    cnt_d   = cnt_q;
    valid_d = valid_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    if (bus.update_en) begin
      if (bus.update_taken) begin
        if (cnt_q[up_idx] != 2'd3) begin
          cnt_d[up_idx] = cnt_q[up_idx] + 2'd1;
        end
        valid_d[up_idx] = 1'b1;
        tag_d[up_idx]   = up_tag;
        tgt_d[up_idx]   = bus.update_target;
      end else if (cnt_q[up_idx] != 2'd0) begin
        cnt_d[up_idx] = cnt_q[up_idx] - 2'd1;
      end
    end
  end

  // Counters start weakly not-taken and all entries invalid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        cnt_q[i] <= 2'b01;
      end
      valid_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  // Tags and targets are qualified by valid, so they need no reset.
  always_ff @(posedge clk) begin
    tag_q <= tag_d;
    tgt_q <= tgt_d;
  end
`else
  logic unused_update;

  assign predict_taken  = 1'b0;
  assign predict_target = pc_plus4;
  assign unused_update  = ^{bus.update_en, bus.update_pc, bus.update_taken,
                            bus.update_target, (BHT_IDX_W != 0)};
`endif

  // Next-PC priority: redirect, then stall hold, then predicted target, then sequential.
  always_comb begin
    if (bus.redirect) begin
      pc_d = bus.redirect_pc;
    end else if (bus.stall) begin
      pc_d = pc_q;
    end else if (predict_taken) begin
      pc_d = predict_target;
    end else begin
      pc_d = pc_plus4;
    end
  end

  // IF/ID next value: a flush bubble beats a stall hold, which beats a normal load.
  always_comb begin
    instr_d  = instr_q;
    pc_if_d  = pc_if_q;
    pcnext_d = pcnext_q;
    pred_d   = pred_q;
    if (bus.flush) begin
      instr_d  = NOP_INSTR;
      pc_if_d  = 32'd0;
      pcnext_d = 32'd0;
      pred_d   = 1'b0;
    end else if (!bus.stall) begin
      instr_d  = bus.imem_rdata;
      pc_if_d  = pc_q;
      pcnext_d = pc_plus4;
      pred_d   = predict_taken;
    end
  end

  // PC and IF/ID state; reset restarts fetch at address 0 with a bubble in IF/ID.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q     <= 32'd0;
      instr_q  <= NOP_INSTR;
      pc_if_q  <= 32'd0;
      pcnext_q <= 32'd0;
      pred_q   <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc_if_q  <= pc_if_d;
      pcnext_q <= pcnext_d;
      pred_q   <= pred_d;
    end
  end

  assign bus.instr_IF      = instr_q;
  assign bus.pc_IF         = pc_if_q;
  assign bus.pcnext_IF     = pcnext_q;
  assign bus.prediction_IF = pred_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_predict_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_predict_stage
// Description : Directed self-checking bench for fetch_predict_stage.
//               Expectations follow BRANCH_PREDICT_EN when it is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_predict_stage;

  localparam logic [31:0] KEY = 32'hC0DE_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef BRANCH_PREDICT_EN
  localparam bit PRED_ON = 1'b1;
`else
  localparam bit PRED_ON = 1'b0;
`endif

  logic clk;
  logic rst;
  int   passed;
  int   total;

  fetch_predict_if bus ();

  fetch_predict_stage #(.BHT_IDX_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Instruction memory: combinational, content derived from the address.
  assign bus.imem_rdata = bus.imem_addr ^ KEY;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic train(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
    bus.update_en     = 1'b1;
    bus.update_pc     = pc;
    bus.update_taken  = taken;
    bus.update_target = tgt;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst               = 1'b1;
    bus.stall         = 1'b0;
    bus.flush         = 1'b0;
    bus.redirect      = 1'b0;
    bus.redirect_pc   = 32'd0;
    bus.update_en     = 1'b0;
    bus.update_pc     = 32'd0;
    bus.update_taken  = 1'b0;
    bus.update_target = 32'd0;

    // Reset state
    step();
    step();
    check("rst_imem_addr", bus.imem_addr, 32'd0);
    check("rst_instr", bus.instr_IF, NOP);
    check("rst_pc_if", bus.pc_IF, 32'd0);
    check("rst_pcnext", bus.pcnext_IF, 32'd0);
    check("rst_pred", {31'd0, bus.prediction_IF}, 32'd0);

    // Sequential fetch after release
    rst = 1'b0;
    check("seq_addr0", bus.imem_addr, 32'd0);
    step();
    check("seq_addr4", bus.imem_addr, 32'd4);
    check("seq_pc_if0", bus.pc_IF, 32'd0);
    check("seq_instr0", bus.instr_IF, KEY);
    check("seq_pcnext0", bus.pcnext_IF, 32'd4);
    step();
    check("seq_addr8", bus.imem_addr, 32'd8);
    check("seq_pc_if4", bus.pc_IF, 32'd4);
    check("seq_instr4", bus.instr_IF, 32'd4 ^ KEY);
    check("seq_pcnext4", bus.pcnext_IF, 32'd8);

    // Two taken updates at 0x40 -> strongly taken, target 0x100
    train(32'h40, 1'b1, 32'h100);
    step();
    step();
    bus.update_en   = 1'b0;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h40;
    step();
    check("tk_addr40", bus.imem_addr, 32'h40);
    bus.redirect = 1'b0;
    step();
    check("tk_pc_if", bus.pc_IF, 32'h40);
    check("tk_pred", {31'd0, bus.prediction_IF}, {31'd0, PRED_ON});
    check("tk_next_addr", bus.imem_addr, PRED_ON ? 32'h100 : 32'h44);

    // Asynchronous reset in mid-cycle
    rst = 1'b1;
    #1;
    check("arst_addr", bus.imem_addr, 32'd0);
    check("arst_instr", bus.instr_IF, NOP);
    check("arst_pred", {31'd0, bus.prediction_IF}, 32'd0);
    step();
    rst = 1'b0;
    check("arst_rel_addr", bus.imem_addr, 32'd0);

    // Taken then not-taken: counter back to 01, no prediction
    train(32'h40, 1'b1, 32'h100);
    step();
    train(32'h40, 1'b0, 32'h0);
    step();
    bus.update_en   = 1'b0;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h40;
    step();
    check("tn_addr40", bus.imem_addr, 32'h40);
    bus.redirect = 1'b0;
    // Same-cycle training must not affect this lookup (01 -> 10 at the edge)
    train(32'h40, 1'b1, 32'h100);
    step();
    check("tn_pred", {31'd0, bus.prediction_IF}, 32'd0);
    check("tn_next_addr", bus.imem_addr, 32'h44);
    bus.update_en   = 1'b0;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h40;
    step();
    bus.redirect = 1'b0;
    step();
    check("post_upd_pred", {31'd0, bus.prediction_IF}, {31'd0, PRED_ON});
    check("post_upd_addr", bus.imem_addr, PRED_ON ? 32'h100 : 32'h44);

    // Aliasing: 0x440 shares index 0 with 0x40 but has a different tag
    train(32'h40, 1'b1, 32'h100);
    step();
    bus.update_en   = 1'b0;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h440;
    step();
    bus.redirect = 1'b0;
    step();
    check("alias_pc_if", bus.pc_IF, 32'h440);
    check("alias_pred", {31'd0, bus.prediction_IF}, 32'd0);
    check("alias_addr", bus.imem_addr, 32'h444);

    // Redirect overrides stall; IF/ID held
    bus.stall       = 1'b1;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h200;
    step();
    check("stred_addr", bus.imem_addr, 32'h200);
    check("stred_pc_if", bus.pc_IF, 32'h440);
    check("stred_instr", bus.instr_IF, 32'h440 ^ KEY);
    check("stred_pcnext", bus.pcnext_IF, 32'h444);
    bus.redirect = 1'b0;
    step();
    check("stall_addr", bus.imem_addr, 32'h200);
    check("stall_pc_if", bus.pc_IF, 32'h440);

    // Flush wins over stall
    bus.flush = 1'b1;
    step();
    check("fl_instr", bus.instr_IF, NOP);
    check("fl_pred", {31'd0, bus.prediction_IF}, 32'd0);
    check("fl_pc_if", bus.pc_IF, 32'd0);
    check("fl_pcnext", bus.pcnext_IF, 32'd0);
    check("fl_addr", bus.imem_addr, 32'h200);
    bus.flush = 1'b0;
    bus.stall = 1'b0;
    step();
    check("resume_pc_if", bus.pc_IF, 32'h200);
    check("resume_instr", bus.instr_IF, 32'h200 ^ KEY);
    check("resume_addr", bus.imem_addr, 32'h204);

    // PC+4 wraps from 0xFFFFFFFC to 0
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFC;
    step();
    check("wrap_addr_top", bus.imem_addr, 32'hFFFF_FFFC);
    bus.redirect = 1'b0;
    step();
    check("wrap_addr0", bus.imem_addr, 32'd0);
    check("wrap_pc_if", bus.pc_IF, 32'hFFFF_FFFC);
    check("wrap_pcnext", bus.pcnext_IF, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_predict_stage.md
FETCH_PREDICT_STAGE -- requirements
Module: fetch_predict_stage

Interface
REQ-001 SHALL have parameter BHT_IDX_W, default 4, giving log2 of the predictor table entry count (16 entries).
REQ-002 SHALL have port clk, input, 1: single clock; all state changes on posedge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-004 SHALL have port stall, input, 1: hold PC and the IF/ID register.
REQ-005 SHALL have port flush, input, 1: load a bubble into the IF/ID register.
REQ-006 SHALL have port redirect, input, 1: EX-stage mispredict or jump correction.
REQ-007 SHALL have port redirect_pc, input, 32: correct next PC when redirect=1.
REQ-008 SHALL have port update_en, input, 1: resolved-branch training strobe from EX.
REQ-009 SHALL have port update_pc, input, 32: PC of the resolved branch.
REQ-010 SHALL have port update_taken, input, 1: resolved outcome.
REQ-011 SHALL have port update_target, input, 32: resolved target.
REQ-012 SHALL have port imem_addr, output, 32: instruction memory address, equal to the current PC.
REQ-013 SHALL have port imem_rdata, input, 32: instruction word, combinational from imem_addr.
REQ-014 SHALL have port instr_IF, output, 32: registered instruction to decode.
REQ-015 SHALL have port pc_IF, output, 32: registered PC of instr_IF.
REQ-016 SHALL have port pcnext_IF, output, 32: registered pc_IF+4.
REQ-017 SHALL have port prediction_IF, output, 1: registered taken prediction for instr_IF.

Function
REQ-018 SHALL hold 2^BHT_IDX_W entries, each: 2-bit saturating counter, valid bit, tag = pc[31:2+BHT_IDX_W], 32-bit target; index = pc[1+BHT_IDX_W:2].
REQ-019 SHALL compute predict_taken = valid & (tag match) & counter[1] for the current PC, combinationally.
REQ-020 SHALL select next PC by priority: redirect -> redirect_pc; else stall -> hold; else predict_taken -> stored target; else PC+4 (mod 2^32, wrap from 0xFFFFFFFC to 0).
REQ-021 SHALL apply redirect even when stall=1 in the same cycle.
REQ-022 SHALL, on a posedge with no stall and no flush, load the IF/ID register from imem_rdata, PC, PC+4 and predict_taken, giving 1-cycle fetch latency.
REQ-023 SHALL, on flush, load instr_IF=32'h00000013 (NOP), prediction_IF=0, and pc_IF/pcnext_IF=0; flush wins over stall.
REQ-024 SHALL, on stall without flush, hold all IF/ID outputs unchanged.
REQ-025 SHALL, on update_en with update_taken=1, increment the indexed counter saturating at 3, and write tag, target and valid=1.
REQ-026 SHALL, on update_en with update_taken=0, decrement the indexed counter saturating at 0, leaving tag, target and valid unchanged.
REQ-027 SHALL update tables on the clock edge so that a same-cycle lookup at the updated index sees the pre-update value.
REQ-028 SHALL train tables regardless of stall, flush or redirect.

Reset
REQ-029 SHALL, while rst=1, force PC=0 (imem_addr=0), instr_IF=32'h00000013, pc_IF=0, pcnext_IF=0, prediction_IF=0.
REQ-030 SHALL, while rst=1, set all counters to 2'b01 and all valid bits to 0; tags and targets are don't-care.
REQ-031 SHALL, on rst asserted mid-operation, take effect immediately; the first fetch after release is from address 0.

Configuration
REQ-032 SHALL, with macro BRANCH_PREDICT_EN defined, implement the predictor per REQ-018..REQ-028.
REQ-033 SHALL, without BRANCH_PREDICT_EN, contain no table storage, tie predict_taken to 0 (prediction_IF always 0), ignore update_* inputs, and take next PC as redirect_pc or PC+4 only.

Verification
REQ-034 SHALL cover: reset release, no stall -> imem_addr 0,4,8; one cycle later pc_IF 0,4 and instr_IF=imem_rdata of each, pcnext_IF=pc_IF+4.
REQ-035 SHALL cover: two taken updates at 0x40 with target 0x100 -> next fetch of 0x40 gives prediction_IF=1 and following imem_addr 0x100.
REQ-036 SHALL cover: one taken update at 0x40 (counter 01->10) then one not-taken update (10->01) -> fetch of 0x40 gives prediction_IF=0, next imem_addr 0x44.
REQ-037 SHALL cover: stall=1 and redirect=1 with redirect_pc=0x200 in the same cycle -> next imem_addr 0x200, IF/ID outputs held.
REQ-038 SHALL cover: flush=1 and stall=1 together -> instr_IF=0x00000013, prediction_IF=0.
REQ-039 SHALL cover: aliasing, with an entry trained at 0x40 and then fetch at 0x440 (same index, different tag) -> prediction_IF=0; and without BRANCH_PREDICT_EN, the REQ-035 stimulus gives prediction_IF=0.
